nibble_rx: RTL
==============

NIBBLE_RX -- requirements
Module: nibble_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst  input  1  reset, asynchronous and active-low; all state SHALL be cleared while rst=0.
REQ-004 rxd  input  1  asynchronous serial line; idles high.
REQ-005 D  output  [3:0]  last good received nibble; feeds the downstream 4-bit register D input.
REQ-006 ld  output  1  one-cycle strobe; D is valid while ld=1; feeds the downstream register load input.
REQ-007 frame_err  output  1  one-cycle strobe: stop bit sampled low.
REQ-008 busy  output  1  high in every state except IDLE.

Function
REQ-009 Frame format SHALL be: start bit (0), 4 data bits LSB first, one stop bit (1).
REQ-010 rxd SHALL pass through a 2-flop synchronizer (flops reset to 1); all logic below uses the synchronized value rxs.
REQ-011 States SHALL be: IDLE, START, DATA, STOP, WAIT_HI.
REQ-012 IDLE: rxs=0 -> START, bit-timer cleared; call this cycle 0.
REQ-013 Sample instants, relative to cycle 0: start at H=CLKS_PER_BIT/2; data bit i (i=0..3) at H+(i+1)*CLKS_PER_BIT; stop at H+5*CLKS_PER_BIT.
REQ-014 START: rxs=1 at the start sample -> false start, back to IDLE with no strobe; rxs=0 -> DATA.
REQ-015 DATA: each sample SHALL be shifted into a 4-bit shift register, LSB first; after bit 3 -> STOP.
REQ-016 STOP, rxs=1: D <= shift register; ld=1 for exactly the following cycle (H+5*CLKS_PER_BIT+1); -> IDLE.
REQ-017 STOP, rxs=0: D unchanged; frame_err=1 for exactly the following cycle; ld stays 0; -> WAIT_HI.
REQ-018 WAIT_HI: SHALL remain until rxs=1, then -> IDLE; a low line SHALL NOT start a new frame from this state.
REQ-019 ld and frame_err SHALL never be high in the same cycle.
REQ-020 D SHALL change only in the cycle ld rises, and SHALL hold its value otherwise.
REQ-021 The bit-timer SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and SHALL restart at every sample instant, with no drift across the frame.
REQ-022 Back-to-back frames: a start edge in the first IDLE cycle after STOP SHALL be accepted.

Reset
REQ-023 While rst=0: state=IDLE, D=4'h0, ld=0, frame_err=0, busy=0, synchronizer flops=1, timer and shift register=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, with no strobe on either output.
REQ-025 After reset release, the block SHALL need a synchronized falling edge to start; a line held low through release SHALL NOT start a frame.

Structure
REQ-026 Package nibble_rx_pkg SHALL hold the state enum typedef and the bit-count constant (4).
REQ-027 The 2-flop synchronizer SHALL be a sub-module sync2 with clk, rst, d, q and a parameterised reset value.
REQ-028 ld and D SHALL be registered outputs, so they connect directly to the downstream register's ld and D inputs.

Verification (CLKS_PER_BIT=16, bits driven at exactly 16-cycle spacing)
REQ-029 Frame 0,0,1,0,1,1 (value 4'hA): ld=1 for one cycle at cycle 89, D=4'hA, frame_err stays 0.
REQ-030 Line low for only 4 cycles, then high: no ld, no frame_err; busy is high 1-8 cycles, then returns to IDLE.
REQ-031 Frame of data 4'h5 with stop=0: frame_err=1 at cycle 89, D keeps its prior value; line held low 40 cycles -> stays in WAIT_HI with no new frame; line goes high -> IDLE.
REQ-032 Two back-to-back frames 4'h3 then 4'hC: two ld pulses 96 cycles apart with D=3 then D=C; downstream register Q tracks both values.
REQ-033 rst=0 at cycle 40 of a frame: outputs go to their reset values asynchronously; after release plus a new frame 4'hF, exactly one ld with D=4'hF.
REQ-034 Line held low through reset release: no activity until the line goes high and then a new falling edge arrives.

Source files
------------

// File: rtl/nibble_rx_pkg.sv
// ============================================================================
// nibble_rx_pkg : shared state encoding and frame constants for nibble_rx
// Revision      : 1.0
// ============================================================================
`default_nettype none

package nibble_rx_pkg;

   localparam int NBITS = 4;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_STOP    = 3'd3,
      S_WAIT_HI = 3'd4
   } state_e;

endpackage

`default_nettype wire

// File: rtl/nibble_rx_sync.sv
// ============================================================================
// sync2    : two-flop synchronizer with parameterised reset value
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/nibble_rx.sv
// ============================================================================
// nibble_rx : serial receiver for start + 4 data (LSB first) + stop frames
// Revision  : 1.0
// ============================================================================
`default_nettype none

module nibble_rx
   import nibble_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [3:0] D,
   output logic       ld,
   output logic       frame_err,
   output logic       busy
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
   localparam logic [1:0]    LAST_BIT = 2'(NBITS - 1);

   generate
      if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT % 2 != 0)) begin : g_param_chk
         $error("CLKS_PER_BIT must be even and >= 4");
      end
   endgenerate

   logic          rxs;
   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    bitcnt_q, bitcnt_d;
   logic [3:0]    sh_q, sh_d;
   logic [3:0]    data_q, data_d;
   logic          ld_q, ld_d;
   logic          ferr_q, ferr_d;
   logic [1:0]    vld_q, vld_d;
   logic          armed_q, armed_d;

   sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rxd),
      .q   (rxs)
   );

   // vld_q[1] marks the synchronizer as flushed of its reset value; armed_q
   // then requires a real high line before any falling edge may start a frame.
   assign vld_d   = {vld_q[0], 1'b1};
   assign armed_d = armed_q | (vld_q[1] & rxs);

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q + 1'b1;
      bitcnt_d = bitcnt_q;
      sh_d     = sh_q;
      data_d   = data_q;
      ld_d     = 1'b0;
      ferr_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (armed_q && !rxs) state_d = S_START;
         end
         S_START: begin
            if (timer_q == HALF_M1) begin
               timer_d  = '0;
               bitcnt_d = '0;
               state_d  = rxs ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (timer_q == FULL_M1) begin
               timer_d  = '0;
               sh_d     = {rxs, sh_q[3:1]};
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == LAST_BIT) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (timer_q == FULL_M1) begin
               timer_d = '0;
               if (rxs) begin
                  data_d  = sh_q;
                  ld_d    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_WAIT_HI;
               end
            end
         end
         S_WAIT_HI: begin
            timer_d = '0;
            if (rxs) state_d = S_IDLE;
         end
         default: begin
            timer_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         bitcnt_q <= '0;
         sh_q     <= '0;
         data_q   <= '0;
         ld_q     <= 1'b0;
         ferr_q   <= 1'b0;
         vld_q    <= '0;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         bitcnt_q <= bitcnt_d;
         sh_q     <= sh_d;
         data_q   <= data_d;
         ld_q     <= ld_d;
         ferr_q   <= ferr_d;
         vld_q    <= vld_d;
         armed_q  <= armed_d;
      end
   end

   assign D         = data_q;
   assign ld        = ld_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire
